// File: rtl/uart_pkg.sv
// UART shared definitions: parity modes, receiver state encoding, bit-period helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package uart_pkg;

    // Parity mode selectors for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Receiver FSM encoding
    localparam int         ST_W      = 3;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Clock cycles per serial bit (integer division, shared with the transmitter)
    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// UART line synchronizer: 2-flop resync of uart_rxd plus falling-edge detect.
// Latency: rxd_s lags the pin by 2 cycles; fall pulses in the cycle rxd_s first reads 0.
// Backpressure: none; free-running.
// Ports: sys_clk/sys_rst clock and async active-low reset, uart_rxd raw pin,
//        rxd_s synchronized line, fall one-cycle falling-edge strobe.
module uart_rx_sync (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    // All flops reset to the idle-high line level so release never fakes an edge
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rxd_s = sync2;
    assign fall  = prev & ~sync2;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: start/data/parity/stop framing with mid-bit sampling.
// Latency: rx_valid one cycle after the final stop-bit mid sample (~2 sync + 1 detect cycles after pin).
// Backpressure: none; rx_valid is a one-cycle pulse, outputs hold until the next frame.
// Ports: sys_clk, sys_rst (async active-low), uart_rxd serial in (idle high, LSB first),
//        rx_data/rx_valid/parity_err/frame_err delivered frame, rx_busy high outside IDLE.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int CNT_W      = $clog2(BIT_PERIOD) + 1;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [3:0]       DATA_M1 = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_M1 = 4'(STOP_BITS - 1);

    generate
        if (BIT_PERIOD < 8) begin : g_bad_period
            $error("uart_rx_cfg: BIT_PERIOD must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
            $error("uart_rx_cfg: DATA_BITS must be 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_cfg: PARITY must be 0..2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_cfg: STOP_BITS must be 1..2");
        end
    endgenerate

    logic                 rxd_s;
    logic                 fall;
    logic [ST_W-1:0]      state;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 fe_acc;
    logic                 armed;
    logic                 tick;
    logic                 stop_fe;
    logic                 perr;

    uart_rx_sync u_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .rxd_s    (rxd_s),
        .fall     (fall)
    );

    // First sample lands half a bit after start detection, every later one a full bit on
    assign tick    = (state == ST_START) ? (cnt == HALF_M1) : (cnt == BIT_M1);
    assign stop_fe = fe_acc | ~rxd_s;
    assign rx_busy = (state != ST_IDLE);

    always_comb begin
        perr = 1'b0;
        if (PARITY == PAR_ODD) begin
            perr = ~((^shift) ^ par_bit);
        end else if (PARITY == PAR_EVEN) begin
            perr = (^shift) ^ par_bit;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            fe_acc     <= 1'b0;
            armed      <= 1'b1;
            rx_data    <= '1;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rxd_s) begin
                armed <= 1'b1;
            end
            if (state == ST_IDLE) begin
                cnt     <= '0;
                bit_idx <= '0;
                if (fall && armed) begin
                    state <= ST_START;
                end
            end else if (!tick) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    ST_START: begin
                        // A start bit that is high again at mid-bit is a glitch
                        if (rxd_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_DATA;
                            fe_acc <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shift <= {rxd_s, shift[DATA_BITS-1:1]};
                        if (bit_idx == DATA_M1) begin
                            bit_idx <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        par_bit <= rxd_s;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_idx == STOP_M1) begin
                            rx_data    <= shift;
                            parity_err <= perr;
                            frame_err  <= stop_fe;
                            rx_valid   <= 1'b1;
                            state      <= ST_IDLE;
                            // A framing error may be a break: wait for the line to go high
                            // before the next start edge is accepted
                            if (stop_fe) begin
                                armed <= 1'b0;
                            end
                        end else begin
                            fe_acc  <= stop_fe;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

    localparam int BP   = 434;
    localparam int HALF = BP / 2;
    localparam int LAT  = BP * 9 + HALF + 3;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst;
    logic [3:0] rxd;

    logic [7:0] d0, d1, d2;
    logic [4:0] d3;
    logic [3:0] v, pe, fe, busy;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   vcnt[4];
    int   last_cyc[4];
    int   cyc;

    // 8N1
    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[0]), .rx_data(d0),
        .rx_valid(v[0]), .parity_err(pe[0]), .frame_err(fe[0]), .rx_busy(busy[0]));
    // 8E1
    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[1]), .rx_data(d1),
        .rx_valid(v[1]), .parity_err(pe[1]), .frame_err(fe[1]), .rx_busy(busy[1]));
    // 8N2
    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[2]), .rx_data(d2),
        .rx_valid(v[2]), .parity_err(pe[2]), .frame_err(fe[2]), .rx_busy(busy[2]));
    // 5O1
    uart_rx_cfg #(.CLK_FREQ(50000000), .BAUD_RATE(115200), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rxd(rxd[3]), .rx_data(d3),
        .rx_valid(v[3]), .parity_err(pe[3]), .frame_err(fe[3]), .rx_busy(busy[3]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on each delivered frame
    task automatic got(input int inst, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        vcnt[inst]++;
        last_cyc[inst] = cyc;
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL unexpected_pulse inst=%0d observed=%0h expected=none", inst, d);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_inst", 32'(inst), 32'(e.inst));
            chk("sb_data", 32'(d), 32'(e.d));
            chk("sb_parity_err", 32'(p), 32'(e.pe));
            chk("sb_frame_err", 32'(f), 32'(e.fe));
        end
    endtask

    always @(negedge sys_clk) if (v[0]) begin
        got(0, d0, pe[0], fe[0]);
        @(negedge sys_clk);
        chk("pulse_width0", 32'(v[0]), 32'd0);
    end
    always @(negedge sys_clk) if (v[1]) begin
        got(1, d1, pe[1], fe[1]);
        @(negedge sys_clk);
        chk("pulse_width1", 32'(v[1]), 32'd0);
    end
    always @(negedge sys_clk) if (v[2]) begin
        got(2, d2, pe[2], fe[2]);
        @(negedge sys_clk);
        chk("pulse_width2", 32'(v[2]), 32'd0);
    end
    always @(negedge sys_clk) if (v[3]) begin
        got(3, {3'b000, d3}, pe[3], fe[3]);
        @(negedge sys_clk);
        chk("pulse_width3", 32'(v[3]), 32'd0);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Drive n bits (bit 0 first, one bit period each), then return line to idle high
    task automatic send(input int inst, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd[inst] = bits[i];
            idle(BP);
        end
        rxd[inst] = 1'b1;
    endtask

    task automatic push(input int inst, input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.inst = 2'(inst);
        e.d    = d;
        e.pe   = p;
        e.fe   = f;
        sb.push_back(e);
    endtask

    // Hard stop in case anything stalls
    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int lat;
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        for (int i = 0; i < 4; i++) begin
            vcnt[i]     = 0;
            last_cyc[i] = 0;
        end
        rxd     = 4'hF;
        sys_rst = 1'b0;
        idle(5);

        // Reset state
        chk("rst_data0", 32'(d0), 32'hFF);
        chk("rst_data3", 32'(d3), 32'h1F);
        chk("rst_valid", 32'(v), 32'h0);
        chk("rst_perr", 32'(pe), 32'h0);
        chk("rst_ferr", 32'(fe), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        sys_rst = 1'b1;
        idle(20);

        // 8N1 0xA5 with latency check
        push(0, 8'hA5, 1'b0, 1'b0);
        c0 = cyc;
        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        idle(2 * BP);
        lat = last_cyc[0] - c0;
        chk("a5_latency_ok", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);
        chk("a5_count", 32'(vcnt[0]), 32'd1);
        chk("a5_hold", 32'(d0), 32'hA5);

        // 8E1 0x07 with wrong then correct parity bit
        push(1, 8'h07, 1'b1, 1'b0);
        send(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        idle(BP);
        chk("e1_hold_perr", 32'(pe[1]), 32'd1);
        push(1, 8'h07, 1'b0, 1'b0);
        send(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        idle(BP);
        chk("e1_perr_clear", 32'(pe[1]), 32'd0);
        chk("e1_count", 32'(vcnt[1]), 32'd2);

        // Glitch: line low 100 cycles
        rxd[0] = 1'b0;
        idle(50);
        chk("glitch_busy_hi", 32'(busy[0]), 32'd1);
        idle(50);
        rxd[0] = 1'b1;
        for (int i = 0; i < HALF + 3 && busy[0]; i++) idle(1);
        chk("glitch_busy_drop", 32'(busy[0]), 32'd0);
        idle(BP);
        chk("glitch_no_pulse", 32'(vcnt[0]), 32'd1);
        chk("glitch_data_hold", 32'(d0), 32'hA5);

        // 8N2 0x3C with second stop bit low
        push(2, 8'h3C, 1'b0, 1'b1);
        send(2, 16'({1'b0, 1'b1, 8'h3C, 1'b0}), 11);
        idle(BP);
        chk("n2_ferr_hold", 32'(fe[2]), 32'd1);

        // Break: line low for well past one frame
        push(2, 8'h00, 1'b0, 1'b1);
        rxd[2] = 1'b0;
        idle(12 * BP);
        chk("brk_count", 32'(vcnt[2]), 32'd2);
        idle(5 * BP);
        chk("brk_no_rearm_busy", 32'(busy[2]), 32'd0);
        chk("brk_no_rearm_count", 32'(vcnt[2]), 32'd2);
        rxd[2] = 1'b1;
        idle(2 * BP);
        chk("brk_high_idle", 32'(busy[2]), 32'd0);
        push(2, 8'h81, 1'b0, 1'b0);
        send(2, 16'({2'b11, 8'h81, 1'b0}), 11);
        idle(BP);
        chk("brk_rearm_count", 32'(vcnt[2]), 32'd3);

        // Reset during data bit 3 of 0x55
        rxd[0] = 1'b0; idle(BP);
        rxd[0] = 1'b1; idle(BP);
        rxd[0] = 1'b0; idle(BP);
        rxd[0] = 1'b1; idle(BP);
        rxd[0] = 1'b0; idle(HALF);
        chk("mid_busy_before_rst", 32'(busy[0]), 32'd1);
        sys_rst = 1'b0;
        rxd[0]  = 1'b1;
        idle(5);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_data", 32'(d0), 32'hFF);
        sys_rst = 1'b1;
        idle(2 * BP);
        chk("mid_no_pulse", 32'(vcnt[0]), 32'd1);
        push(0, 8'hC3, 1'b0, 1'b0);
        send(0, 16'({1'b1, 8'hC3, 1'b0}), 10);
        idle(BP);
        chk("c3_count", 32'(vcnt[0]), 32'd2);

        // 5O1 back-to-back 0x15 (parity 0) and 0x0A (parity 1)
        push(3, 8'h15, 1'b0, 1'b0);
        push(3, 8'h0A, 1'b0, 1'b0);
        send(3, 16'({1'b1, 1'b0, 5'h15, 1'b0}), 8);
        send(3, 16'({1'b1, 1'b1, 5'h0A, 1'b0}), 8);
        idle(2 * BP);
        chk("o1_count", 32'(vcnt[3]), 32'd2);
        chk("o1_hold", 32'(d3), 32'h0A);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz, SHALL be provided.
REQ-002 Parameter BAUD_RATE, 9600, line rate in bit/s, SHALL be provided.
REQ-003 Parameter DATA_BITS, 8, data bits per frame, legal 5..8, SHALL be provided.
REQ-004 Parameter PARITY, 0, parity mode: 0 none, 1 odd, 2 even, SHALL be provided.
REQ-005 Parameter STOP_BITS, 1, stop bits per frame, legal 1..2, SHALL be provided.
REQ-006 Port sys_clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-007 Port sys_rst, input, 1: the reset is asynchronous and active-low.
REQ-008 Port uart_rxd, input, 1, asynchronous serial line, idle high, LSB first.
REQ-009 Port rx_data, output, DATA_BITS, last received data word.
REQ-010 Port rx_valid, output, 1, one-cycle pulse when a complete frame is delivered.
REQ-011 Port parity_err, output, 1, parity mismatch on the delivered frame; always 0 when PARITY=0.
REQ-012 Port frame_err, output, 1, at least one stop bit sampled low on the delivered frame.
REQ-013 Port rx_busy, output, 1, high in every state except IDLE.

Function
REQ-014 BIT_PERIOD SHALL equal CLK_FREQ/BAUD_RATE (integer division); HALF SHALL equal BIT_PERIOD/2.
REQ-015 BIT_PERIOD < 8, DATA_BITS outside 5..8, PARITY > 2 or STOP_BITS outside 1..2 SHALL fail elaboration.
REQ-016 uart_rxd SHALL pass a 2-flop synchronizer (flops reset to 1) before any use.
REQ-017 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE -> START on a falling edge (1 then 0) of the synchronized line; the bit counter SHALL clear.
REQ-019 START: the line SHALL be sampled HALF cycles after start detection; if high, the event is a glitch -> IDLE with no output change.
REQ-020 Each later sample SHALL occur exactly BIT_PERIOD cycles after the previous one (mid-bit).
REQ-021 DATA: DATA_BITS samples shifted in LSB first, then -> PARITY if PARITY != 0, else -> STOP.
REQ-022 PARITY: one sample; parity_err is computed over data bits plus the parity bit (odd: XOR must be 1; even: XOR must be 0).
REQ-023 STOP: STOP_BITS samples; any low sample SHALL set frame_err for the frame.
REQ-024 The cycle after the final stop sample: rx_data, parity_err and frame_err SHALL update together, rx_valid SHALL pulse high for exactly one cycle, and the state SHALL return to IDLE.
REQ-025 rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-026 A falling edge arriving immediately after the stop-bit mid sample SHALL start a new frame (back-to-back frames with no idle gap).
REQ-027 After a frame_err with the line held low (break), IDLE SHALL NOT re-arm until the line has been high for at least one cycle.
REQ-028 Bit counter width SHALL be $clog2(BIT_PERIOD)+1; the counter SHALL never wrap within a bit.

Reset
REQ-029 While sys_rst=0: state IDLE, counters 0, synchronizer 1, rx_data all ones, rx_valid 0, parity_err 0, frame_err 0, rx_busy 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame with no rx_valid pulse; reception SHALL resume on the next falling edge after release.

Structure
REQ-031 Package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN), the state encoding, and a bit-period function shared with the future transmitter.
REQ-032 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer and falling-edge detect; all other logic SHALL remain in uart_rx_cfg.

Verification (CLK_FREQ=50000000, BAUD_RATE=115200, BIT_PERIOD=434)
REQ-033 8N1, frame 0xA5 -> single rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, rx_valid at 434*9+217+3 cycles (+/-1) after the pin edge.
REQ-034 8E1, data 0x07 sent with parity bit 0 -> rx_data=0x07, parity_err=1; repeat with parity bit 1 -> parity_err=0.
REQ-035 Line low for 100 cycles, then high -> no rx_valid, rx_busy drops within HALF+3 cycles.
REQ-036 8N2, frame 0x3C with second stop bit low -> rx_data=0x3C, frame_err=1; then a 0-byte break -> frame_err=1 and no re-arm until the line goes high.
REQ-037 Reset pulsed during data bit 3 of 0x55, then clean frame 0xC3 -> no pulse for 0x55, rx_data=0xC3 with one pulse.
REQ-038 5O1 back-to-back frames 0x15, 0x0A with no idle gap -> two rx_valid pulses, values 0x15 then 0x0A, no errors.
